// File: rtl/cdc_status_arbiter.sv
// rtl/cdc_status_arbiter.sv - round-robin sharer of the 8-bit status CDC channel
//
// Purpose:
//   Source-domain arbiter. It grants one of N_REQ requesters at a time and
//   places {id[1:0], payload[5:0]} on the CDC data input. It then holds that
//   word for HOLD_CYCLES source clocks, so the slow destination side always
//   samples a coherent multi-bit value without needing a handshake.
//
// Ports:
//   clk_i       source-domain clock
//   rst_ni      asynchronous active-low reset
//   req_i       per-requester level request, held until its gnt_o pulse
//   payload_i   6-bit payload of requester k on bits [6k+5:6k]
//   gnt_o       one-hot single-cycle grant pulse
//   cdc_data_o  {id, payload} to the CDC block's source-domain data register
//   busy_o      high while a word is being held

module cdc_status_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [6*N_REQ-1:0] payload_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [7:0]         cdc_data_o,
    output logic               busy_o
);

    localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;

    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        data_d   = data_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                // Scan starting just after the last winner; the first hit wins.
                for (int i = 1; i <= N_REQ; i++) begin
                    idx = (int'(rr_ptr_q) + i) % N_REQ;
                    if (!found && req_i[idx]) begin
                        found       = 1'b1;
                        gnt_d[idx]  = 1'b1;
                        data_d      = {idx[1:0], payload_i[6*idx +: 6]};
                        rr_ptr_d    = idx[1:0];
                        cnt_d       = CNT_W'(HOLD_CYCLES - 1);
                        state_d     = ST_HOLD;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Requests and payloads are ignored here; the word stays put.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            // Pointing at the last index makes requester 0 win first.
            rr_ptr_q <= 2'(N_REQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign cdc_data_o = data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_cdc_status_arbiter.sv
// tb/tb_cdc_status_arbiter.sv - directed table and sequence bench for cdc_status_arbiter

module tb_cdc_status_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] pay;
    logic [3:0]  gnt;
    logic [7:0]  data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    cdc_status_arbiter #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .payload_i  (pay),
        .gnt_o      (gnt),
        .cdc_data_o (data),
        .busy_o     (busy)
    );

    typedef struct {
        logic [3:0]  req;
        logic [23:0] pay;
        logic [3:0]  gnt;
        logic [7:0]  data;
        logic        busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_gnt(input int budget, output logic [3:0] g);
        int n;
        n = 0;
        g = '0;
        while (n < budget && g == '0) begin
            step();
            n++;
            g = gnt;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && busy !== 1'b0) begin
            step();
            n++;
        end
    endtask

    initial begin
        logic [3:0] g;
        int         gcyc[5];
        logic [3:0] exp_g[5];
        logic [7:0] exp_d[5];
        int         c0;
        logic [23:0] p4;

        // Single-request sequence: requester 2, payload 6'h15 -> word 8'h95.
        vecs[0] = '{4'b0000, 24'h015000, 4'b0000, 8'h00, 1'b0};
        vecs[1] = '{4'b0100, 24'h015000, 4'b0100, 8'h95, 1'b1};
        for (int i = 2; i <= 8; i++)  vecs[i] = '{4'b0000, 24'h015000, 4'b0000, 8'h95, 1'b1};
        for (int i = 9; i <= 11; i++) vecs[i] = '{4'b0000, 24'h015000, 4'b0000, 8'h95, 1'b0};

        // Reset with arbitrary inputs.
        rst_n = 1'b0;
        req   = 4'($urandom);
        pay   = 24'($urandom);
        step();
        step();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        #2 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle_after_reset_%0d", i), {gnt, data, busy}, {4'b0000, 8'h00, 1'b0});
        end

        // Table-driven single request.
        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req;
            pay = vecs[i].pay;
            step();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // All four requesting from a fresh reset: order 0,1,2,3,0, 9 cycles apart.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        p4 = {6'h3C, 6'h33, 6'h22, 6'h11};
        pay = p4;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{8'h11, 8'h62, 8'hB3, 8'hFC, 8'h11};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(30, g);
            gcyc[k] = cyc;
            check($sformatf("rr_gnt_%0d", k), 32'(g), 32'(exp_g[k]));
            check($sformatf("rr_data_%0d", k), 32'(data), 32'(exp_d[k]));
            if (k > 0) check($sformatf("rr_spacing_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd9);
            req = req & ~g;
            step();
            check($sformatf("rr_pulse_%0d", k), 32'(gnt), 32'h0);
            req = (k == 4) ? 4'b0000 : 4'b1111;
        end

        // Fairness: after a grant to 1, requests on 1 and 3 -> 3 then 1.
        wait_idle(30);
        req = 4'b0010;
        wait_gnt(30, g);
        check("fair_first_1", 32'(g), 32'h2);
        req = 4'b1010;
        wait_gnt(30, g);
        check("fair_then_3", 32'(g), 32'h8);
        req = 4'b0010;
        wait_gnt(30, g);
        check("fair_then_1", 32'(g), 32'h2);
        req = 4'b0000;

        // Request during HOLD with payload changing before its grant.
        wait_idle(30);
        pay = 24'h000005;
        req = 4'b0001;
        wait_gnt(30, g);
        c0 = cyc;
        check("hold_first_gnt0", 32'(g), 32'h1);
        req = 4'b0100;
        pay = 24'h001005;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_no_gnt_%0d", i), 32'(gnt), 32'h0);
        end
        pay = 24'h02A005;
        wait_gnt(30, g);
        check("hold_late_gnt2", 32'(g), 32'h4);
        check("hold_late_spacing", 32'(cyc - c0), 32'd9);
        check("hold_late_data", 32'(data), 32'hAA);
        req = 4'b0000;

        // Reset in the 4th HOLD cycle abandons the word; rr pointer restarts.
        wait_idle(30);
        pay = 24'h000247;
        req = 4'b0001;
        wait_gnt(30, g);
        check("rst_pre_gnt0", 32'(g), 32'h1);
        check("rst_pre_data", 32'(data), 32'h07);
        req = 4'b0000;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_async", {gnt, data, busy}, {4'b0000, 8'h00, 1'b0});
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("rst_no_reissue_%0d", i), {gnt, data, busy}, {4'b0000, 8'h00, 1'b0});
        end
        req = 4'b0011;
        wait_gnt(30, g);
        check("rst_after_gnt0", 32'(g), 32'h1);
        check("rst_after_data", 32'(data), 32'h07);
        req = 4'b0001 & 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdc_status_arbiter.md
Name: cdc_status_arbiter

Overview:
- Source-domain controller that shares the 8-bit two-flop CDC channel to the status module between up to four requesters.
- Grants requesters round-robin and packs each granted word as {id[1:0], payload[5:0]}.
- Holds each word stable for HOLD_CYCLES source clocks, so the slow destination clock samples a coherent multi-bit value without a handshake.
- Drives the CDC block's source-domain data input directly.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..4, bounded by the 2-bit id field.
- HOLD_CYCLES, 8, source cycles each word stays on cdc_data_o before the next grant is possible; must be >= 2 and must cover at least 3 destination clock periods.

Ports:
- clk_i  input  1  source-domain clock (same clock as the CDC block's fast-side register).
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  N_REQ  request per requester; level, held until the matching gnt_o pulse.
- payload_i  input  6*N_REQ  payload of requester k on bits [6k+5:6k]; must be stable while req_i[k] is high.
- gnt_o  output  N_REQ  one-hot, single-cycle grant pulse.
- cdc_data_o  output  8  {id[1:0], payload[5:0]} to the CDC data input.
- busy_o  output  1  high while in HOLD.

Behaviour:
- Reset (asynchronous, immediate on rst_ni low):
  - Outputs: cdc_data_o=8'h00, gnt_o=0, busy_o=0.
  - Internal: state=IDLE, rr_ptr=N_REQ-1, hold counter=0.
  - After release, requester 0 has highest priority.
- States: IDLE, HOLD. All outputs are registered.
- IDLE, no request: all outputs hold their values; cdc_data_o is never cleared.
- IDLE, any req_i[k] high at a rising edge:
  - Selection: first requesting index found scanning rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - At that edge: cdc_data_o <= {k[1:0], payload_i[6k+5:6k]}, gnt_o[k] <= 1, rr_ptr <= k, counter <= HOLD_CYCLES-1, state <= HOLD.
- HOLD:
  - gnt_o returns to 0 after exactly one cycle.
  - Counter decrements each cycle; req_i and payload_i are ignored.
  - When counter==0: state <= IDLE, busy_o <= 0.
  - cdc_data_o is stable for exactly HOLD_CYCLES cycles of HOLD plus at least 1 IDLE cycle.
- Throughput and latency:
  - Minimum spacing between consecutive cdc_data_o updates is HOLD_CYCLES+1 cycles.
  - Grant latency from an eligible sampled request is 1 cycle.
- Requester rule: deassert req_i[k] in the cycle gnt_o[k] is seen. A request still high on return to IDLE counts as a new request and is arbitrated normally.
- Payload is captured only at the grant edge. Changes before that edge are taken; changes after it are ignored.
- Requests arriving during HOLD wait; nothing is dropped as long as req stays high.
- Simultaneous requests: only one grant per arbitration. Round-robin guarantees each continuously requesting index a grant within N_REQ arbitrations.
- Reset mid-HOLD: the in-flight word is abandoned, cdc_data_o=0 immediately, and no grant is reissued for it.
- N_REQ < 4: unused id codes are never produced.
- The encoding carries status semantics (latest value per id). A repeated identical word is indistinguishable at the destination, by design.

Test Plan:
- Reset: drive rst_ni=0 with random inputs -> cdc_data_o=8'h00, gnt_o=0, busy_o=0; after release with no requests, outputs stay constant for 20 cycles.
- Single request: req_i[2]=1, payload 6'h15 -> gnt_o=4'b0100 for exactly 1 cycle, cdc_data_o=8'h95 from that cycle on, busy_o high 8 cycles, then IDLE; 8'h95 persists.
- All four requesting, each deasserting on grant and re-asserting immediately -> grant order 0,1,2,3,0, consecutive grants exactly 9 cycles apart; cdc_data_o ids follow the same order.
- Fairness after a grant to 1: next requests on 1 and 3 together -> 3 granted first, then 1.
- Request arrives during HOLD; payload changes 6'h01->6'h2A before the grant -> no grant until IDLE, then captured payload is 6'h2A.
- rst_ni pulsed low in the 4th HOLD cycle -> cdc_data_o=0 asynchronously; after release with requests on 1 and 0 -> 0 granted first (rr_ptr reset).
